// File: rtl/sop_error_scanner_if.sv
// Harness-side bundle for sop_error_scanner: scan request, circuit vector/outputs, and scan results.
interface sop_error_scanner_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
);
  logic             start;
  logic [IN_W-1:0]  test_vec;
  logic [OUT_W-1:0] exact_out;
  logic [OUT_W-1:0] approx_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] max_err;
  logic [IN_W:0]    err_count;

  modport master (
    input  start, exact_out, approx_out,
    output test_vec, busy, done, pass, max_err, err_count
  );

  modport slave (
    output start, exact_out, approx_out,
    input  test_vec, busy, done, pass, max_err, err_count
  );
endinterface

// File: rtl/sop_error_scanner.sv
// Sweeps all 2^IN_W vectors through exact/approx circuits and reports worst |error| vs ET; done 2^IN_W+1 edges
// after start, start ignored while not IDLE. SUBXPAT_EARLY_ABORT_EN: stop at the first violation.
module sop_error_scanner #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int ET    = 1
) (
  input logic              clk,
  input logic              rst_n,
  sop_error_scanner_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [IN_W-1:0] LAST_VEC = '1;
  localparam int unsigned     ET_U     = ET;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  vec;
  logic [OUT_W:0]   diff;
  logic [OUT_W:0]   diff_neg;
  logic [OUT_W-1:0] mag;
  logic [OUT_W-1:0] d_dat;
  logic             d_vld;
  logic [OUT_W-1:0] max_err;
  logic [IN_W:0]    err_count;
  logic             viol;
  logic             abort;
  logic             busy;
  logic             done;

  // Extra sign bit so the magnitude of a negative difference is recovered exactly.
  assign diff     = {1'b0, bus.exact_out} - {1'b0, bus.approx_out};
  assign diff_neg = -diff;
  assign mag      = diff[OUT_W] ? diff_neg[OUT_W-1:0] : diff[OUT_W-1:0];

  assign viol = d_vld && (32'(d_dat) > ET_U);

`ifdef SUBXPAT_EARLY_ABORT_EN
  assign abort = viol && (err_count == '0);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = DONE;
        end else if (vec == LAST_VEC) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec       <= '0;
      d_dat     <= '0;
      d_vld     <= 1'b0;
      max_err   <= '0;
      err_count <= '0;
    end else begin
      // An aborting edge drops whatever stage 1 captured in the same edge.
      d_vld <= (state == SCAN) && !abort;
      if (state == SCAN) d_dat <= mag;

      if (state == IDLE && bus.start) begin
        vec       <= '0;
        max_err   <= '0;
        err_count <= '0;
      end else begin
        if (state == SCAN && !abort) vec <= vec + 1'b1;
        if (d_vld) begin
          if (d_dat > max_err) max_err <= d_dat;
          if (viol) err_count <= err_count + 1'b1;
        end
      end
    end
  end

  assign bus.test_vec  = vec;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.max_err   = max_err;
  assign bus.err_count = err_count;
  assign bus.pass      = (32'(max_err) <= ET_U);

endmodule

// File: tb/tb_sop_error_scanner.sv
// Directed bench for sop_error_scanner: scan-timeline model checked every cycle plus literal result pins.
module tb_sop_error_scanner;

  localparam int IN_W  = 4;
  localparam int OUT_W = 3;
  localparam int ET    = 1;
  localparam int N     = 1 << IN_W;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sop_error_scanner_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sop_error_scanner #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [OUT_W-1:0] exact_tbl  [N];
  logic [OUT_W-1:0] approx_tbl [N];
  logic [OUT_W-1:0] snap_e     [N];
  logic [OUT_W-1:0] snap_a     [N];

  assign bus.exact_out  = exact_tbl[bus.test_vec];
  assign bus.approx_out = approx_tbl[bus.test_vec];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  // k: edges since the accepted start edge (-1 = never started since reset); lim: edge of the last accumulate.
  int k   = -1;
  int lim = N + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int err_of(input int e, input int a);
    return (e > a) ? e - a : a - e;
  endfunction

  function automatic int calc_lim();
    int l;
    l = N + 1;
`ifdef SUBXPAT_EARLY_ABORT_EN
    for (int i = N - 1; i >= 0; i--)
      if (err_of(int'(exact_tbl[i]), int'(approx_tbl[i])) > ET) l = i + 2;
`endif
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= -1;
    end else if ((k < 0 || k > lim) && bus.start) begin
      k      <= 0;
      lim    <= calc_lim();
      snap_e <= exact_tbl;
      snap_a <= approx_tbl;
    end else if (k >= 0) begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin : cmp
    int tv, n, mx, cnt, d;
    int eb, ed;
    if (k < 0) begin
      tv = 0; n = 0; eb = 0; ed = 0;
    end else begin
      tv = ((k < lim - 1) ? k : lim - 1) % N;
      n  = (k - 1 < 0) ? 0 : k - 1;
      if (n > lim - 1) n = lim - 1;
      eb = (k < lim) ? 1 : 0;
      ed = (k == lim) ? 1 : 0;
    end
    mx = 0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      d = err_of(int'(snap_e[i]), int'(snap_a[i]));
      if (d > mx) mx = d;
      if (d > ET) cnt++;
    end
    check("cyc_test_vec", int'(bus.test_vec), tv);
    check("cyc_busy", int'(bus.busy), eb);
    check("cyc_done", int'(bus.done), ed);
    check("cyc_max_err", int'(bus.max_err), mx);
    check("cyc_err_count", int'(bus.err_count), cnt);
    if (k < 0 || k >= lim) check("cyc_pass", int'(bus.pass), (mx <= ET) ? 1 : 0);
    if (bus.done) n_done++;
  end

  task automatic set_tbl(input int mode);
    for (int i = 0; i < N; i++) begin
      exact_tbl[i]  = OUT_W'(i % 8);
      approx_tbl[i] = OUT_W'(i % 8);
    end
    case (mode)
      1: approx_tbl[5] = 3'd6;
      2: begin approx_tbl[2] = 3'd3; approx_tbl[9] = 3'd4; approx_tbl[12] = 3'd1; end
      3: begin approx_tbl[0] = 3'd7; approx_tbl[15] = 3'd0; end
      4: begin approx_tbl[3] = 3'd5; approx_tbl[10] = 3'd7; end
      default: ;
    endcase
  endtask

  task automatic run_scan(input string nm, input bit repulse, input int exp_edge,
                          input int exp_max, input int exp_cnt, input int exp_pass);
    int edges;
    int d0;
    d0 = n_done;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    edges = 0;
    while (!bus.done && edges < 100) begin
      bus.start = repulse && (edges == 5);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({nm, "_done_edge"}, edges, exp_edge);
    check({nm, "_max_err"}, int'(bus.max_err), exp_max);
    check({nm, "_err_count"}, int'(bus.err_count), exp_cnt);
    check({nm, "_pass"}, int'(bus.pass), exp_pass);
    if (repulse) begin
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk); bus.start = 1'b0;
      check({nm, "_idle_busy"}, int'(bus.busy), 0);
      check({nm, "_idle_done"}, int'(bus.done), 0);
    end
    repeat (3) @(negedge clk);
    check({nm, "_done_pulses"}, n_done - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    bus.start = 1'b0;
    set_tbl(0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_test_vec", int'(bus.test_vec), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_max_err", int'(bus.max_err), 0);
    check("rst_err_count", int'(bus.err_count), 0);
    check("rst_pass", int'(bus.pass), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scan("equal", 1'b0, 17, 0, 0, 1);
    set_tbl(1);
    run_scan("vec5", 1'b0, 17, 1, 0, 1);
`ifdef SUBXPAT_EARLY_ABORT_EN
    set_tbl(4);
    run_scan("abort", 1'b0, 5, 2, 1, 0);
    check("abort_frozen_vec", int'(bus.test_vec), 4);
`else
    set_tbl(2);
    run_scan("three", 1'b0, 17, 3, 2, 0);
    set_tbl(3);
    run_scan("edges7", 1'b0, 17, 7, 2, 0);
`endif
    set_tbl(0);
    run_scan("repulse", 1'b1, 17, 0, 0, 1);

    // Mid-scan asynchronous reset, asserted between clock edges.
    set_tbl(2);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.test_vec != 4'd7; i++) @(negedge clk);
    check("pre_rst_test_vec", int'(bus.test_vec), 7);
    check("pre_rst_max_err", int'(bus.max_err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_test_vec", int'(bus.test_vec), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_max_err", int'(bus.max_err), 0);
    check("arst_err_count", int'(bus.err_count), 0);
    check("arst_pass", int'(bus.pass), 1);
    @(negedge clk); rst_n = 1'b1;
    set_tbl(1);
    run_scan("post_rst", 1'b0, 17, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sop_error_scanner.md
# sop_error_scanner

Sequencing controller that exhaustively drives every input vector into an approximate SOP circuit and its exact reference circuit in lockstep, then reports the worst-case absolute error against the error threshold. It sits between the testbench or host harness and a pair of combinational circuits (approximate and exact) that share the same input vector. It produces a single pass/fail verdict per scan, used to qualify a synthesized approximate candidate on silicon or in emulation.

## Interface
- `IN_W`, default 4: number of circuit inputs; the scan covers 2^IN_W vectors.
- `OUT_W`, default 3: output width of both circuits, interpreted as unsigned.
- `ET`, default 1: error threshold; a vector violates when its absolute error is greater than ET.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: scan request, sampled only in IDLE.
- `test_vec` output IN_W: vector driven to both circuits; bit i drives `in<i>`.
- `exact_out` input OUT_W: exact circuit output for the current `test_vec`.
- `approx_out` input OUT_W: approximate circuit output for the current `test_vec`.
- `busy` output 1: high in SCAN and DRAIN.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.
- `pass` output 1: 1 when `max_err` <= ET.
- `max_err` output OUT_W: largest |exact−approx| seen in the scan.
- `err_count` output IN_W+1: number of violating vectors.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE → SCAN on `start`=1. This transition clears `max_err` and `err_count`, and sets `test_vec`=0.
  - SCAN: `test_vec` increments every cycle. Leaving `test_vec`=2^IN_W−1 moves the FSM to DRAIN; `test_vec` wraps to 0.
  - DRAIN: lasts exactly 1 cycle, then moves to DONE.
  - DONE: lasts 1 cycle with `done`=1, then returns to IDLE.
- Two-stage pipeline:
  - Stage 1: registers d = |exact_out − approx_out| and a valid flag at each SCAN edge. The subtraction is computed in OUT_W+1 bits; the magnitude fits in OUT_W bits.
  - Stage 2: on valid, max_err ← max(max_err, d), and err_count increments if d > ET.
- `pass` is combinational from `max_err`. It is meaningful only from `done` onward.
- Results hold until the next accepted `start`.
- `start` is ignored in SCAN, DRAIN and DONE. There is no queuing.
- `err_count` cannot overflow: its maximum value is 2^IN_W.

## Timing
- Reset values: `test_vec`=0, `busy`=0, `done`=0, `max_err`=0, `err_count`=0, `pass`=1; FSM in IDLE; pipeline valids cleared.
- Counting the start-sampling edge as E0:
  - Edge Ek (k=1..2^IN_W) registers the error of vector k−1.
  - Edge Ek+1 accumulates that error.
  - The last accumulate occurs at E(2^IN_W+1).
  - `done` is high for the single cycle following E(2^IN_W+1). For IN_W=4 that is after E17.
- `test_vec` is stable for a whole cycle. Both circuits must settle within one clock period.
- If `rst_n` is asserted mid-scan, all state returns to reset values immediately, with no `done` pulse.
- If `start`=1 in the DONE cycle, it is ignored. A new scan needs `start` sampled in IDLE.

## Configuration
- `SUBXPAT_EARLY_ABORT_EN`
  - Defined: the edge that increments `err_count` from 0 to 1 also moves the FSM directly to DONE. Any in-flight stage-1 sample is discarded and `test_vec` freezes. Final results are `err_count`=1, `pass`=0, and `max_err` equal to the first violating error.
  - Undefined: the full scan always runs, with timing exactly as above.

## Test plan
- approx_out == exact_out for all vectors, start pulse at E0 → `done` after E17; `pass`=1, `max_err`=0, `err_count`=0.
- approx_out = exact_out+1 only at vector 5 → `max_err`=1, `err_count`=0, `pass`=1 (threshold is inclusive).
- |error|=3 at vectors 9 and 12, error 1 at vector 2 → `max_err`=3, `err_count`=2, `pass`=0.
- `start` re-pulsed at E6 and again in the DONE cycle → neither is accepted; exactly one `done`, after E17; FSM is in IDLE after E18.
- `rst_n` low while `test_vec`=7 → all outputs at reset values asynchronously; a following `start` runs a clean 17-edge scan.
- With `SUBXPAT_EARLY_ABORT_EN` defined, error 2 at vector 3 → `done` after E5; `err_count`=1, `max_err`=2, `pass`=0, `test_vec` frozen.
